// File: rtl/am_arbiter_pkg.sv
// Shared types and helpers for the associative-memory SRAM arbiter.
package am_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_e;

    // Modular add for port indices where the port count need not be a power of two.
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/am_arbiter_rr_arbiter.sv
// Combinational request picker: round-robin from ptr (mode=1) or lowest index (mode=0).
module rr_arbiter
    import am_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ID_W      = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_W-1:0]      ptr,
    input  logic                 mode,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [ID_W-1:0]      gnt_id
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = mode ? ID_W'(wrap_add(32'(ptr), i, NUM_PORTS)) : ID_W'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        if (found) gnt = NUM_PORTS'(1) << gnt_id;
    end

endmodule

// File: rtl/am_arbiter.sv
// N-port valid/ready arbiter in front of the AM SRAM with burst lock and
// read-response routing after the fixed SRAM latency.
module am_arbiter
    import am_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned HV_LENGTH  = 2048,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned RR_MODE    = 1,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_PORTS-1:0]                 req_valid_i,
    output logic [NUM_PORTS-1:0]                 req_ready_o,
    input  logic [NUM_PORTS-1:0]                 req_wen_i,
    input  logic [NUM_PORTS-1:0]                 req_lock_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     req_addr_i,
    input  logic [NUM_PORTS-1:0][HV_LENGTH-1:0]  req_wdata_i,
    output logic [NUM_PORTS-1:0]                 rsp_valid_o,
    output logic [HV_LENGTH-1:0]                 rsp_rdata_o,
    output logic [ADDR_W-1:0]                    sram_addr_o,
    output logic                                 sram_ren_o,
    output logic                                 sram_wen_o,
    output logic [HV_LENGTH-1:0]                 sram_wdata_o,
    input  logic [HV_LENGTH-1:0]                 sram_rdata_i,
    output logic [$clog2(NUM_PORTS)-1:0]         grant_id_o,
    output logic                                 busy_o
);

    localparam int unsigned ID_W  = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    // Port-id width depends on NUM_PORTS, so these types live per instance.
    typedef logic [ID_W-1:0] port_id_t;
    typedef struct packed {
        logic     vld;
        port_id_t id;
    } rd_pipe_t;

    lock_state_e      state;
    port_id_t         owner;
    port_id_t         rr_ptr;
    logic [CNT_W-1:0] cnt;
    rd_pipe_t         rd_pipe [RD_LATENCY];
    rd_pipe_t         rsp_head;

    logic [NUM_PORTS-1:0] req_elig;
    logic [NUM_PORTS-1:0] gnt;
    port_id_t             gnt_id;
    logic                 any_gnt;
    logic                 gnt_wen;
    logic                 gnt_lock;
    logic                 lock_exit;
    logic                 pipe_busy;

    always_comb begin
        req_elig = rst_ni ? req_valid_i : '0;
        if (state == LOCKED) req_elig &= (NUM_PORTS'(1) << owner);
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ID_W      (ID_W)
    ) u_rr_arbiter (
        .req    (req_elig),
        .ptr    (rr_ptr),
        .mode   (RR_MODE != 0),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign any_gnt     = |gnt;
    assign gnt_wen     = req_wen_i[gnt_id];
    assign gnt_lock    = req_lock_i[gnt_id];
    assign req_ready_o = gnt;
    assign grant_id_o  = gnt_id;

    always_comb begin
        sram_ren_o   = 1'b0;
        sram_wen_o   = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (any_gnt) begin
            sram_ren_o   = ~gnt_wen;
            sram_wen_o   = gnt_wen;
            sram_addr_o  = req_addr_i[gnt_id];
            sram_wdata_o = req_wdata_i[gnt_id];
        end
    end

    // The grant that brings the held count up to LOCK_MAX is the last of the burst.
    assign lock_exit = !gnt_lock || (cnt >= CNT_W'(LOCK_MAX - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            owner  <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else if (any_gnt) begin
            if (RR_MODE != 0) rr_ptr <= port_id_t'(wrap_add(32'(gnt_id), 1, NUM_PORTS));
            case (state)
                IDLE: begin
                    if (gnt_lock && (LOCK_MAX > 1)) begin
                        state <= LOCKED;
                        owner <= gnt_id;
                        cnt   <= CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (lock_exit) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
        end else begin
            rd_pipe[0].vld <= any_gnt & ~gnt_wen;
            rd_pipe[0].id  <= gnt_id;
            for (int unsigned i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign rsp_head = rd_pipe[RD_LATENCY-1];

    always_comb begin
        pipe_busy = 1'b0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_busy |= rd_pipe[i].vld;
    end

    assign rsp_valid_o = (rst_ni && rsp_head.vld) ? (NUM_PORTS'(1) << rsp_head.id) : '0;
    assign rsp_rdata_o = (rst_ni && rsp_head.vld) ? sram_rdata_i : '0;
    assign busy_o      = rst_ni & (pipe_busy | (|req_valid_i));

endmodule

// File: tb/tb_am_arbiter.sv
// Directed bench: instance A is round-robin with burst lock and 2-cycle SRAM,
// instance B is fixed priority with 1-cycle SRAM.
module tb_am_arbiter;

    logic clk;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: RR_MODE=1, RD_LATENCY=2, LOCK_MAX=4
    logic             rst_a_n;
    logic [2:0]       valid_a, ready_a, wen_a, lock_a, rsp_a;
    logic [2:0][3:0]  addr_a;
    logic [2:0][15:0] wdata_a;
    logic [15:0]      rdata_a, sram_wdata_a, sram_rdata_a;
    logic [3:0]       sram_addr_a;
    logic             sram_ren_a, sram_wen_a, busy_a;
    logic [1:0]       gid_a;

    // instance B: RR_MODE=0, RD_LATENCY=1, LOCK_MAX=16
    logic             rst_b_n;
    logic [2:0]       valid_b, ready_b, wen_b, lock_b, rsp_b;
    logic [2:0][3:0]  addr_b;
    logic [2:0][15:0] wdata_b;
    logic [15:0]      rdata_b, sram_wdata_b, sram_rdata_b;
    logic [3:0]       sram_addr_b;
    logic             sram_ren_b, sram_wen_b, busy_b;
    logic [1:0]       gid_b;

    am_arbiter #(
        .NUM_PORTS (3), .HV_LENGTH (16), .ADDR_W (4),
        .RD_LATENCY (2), .RR_MODE (1), .LOCK_MAX (4)
    ) dut_a (
        .clk_i (clk), .rst_ni (rst_a_n),
        .req_valid_i (valid_a), .req_ready_o (ready_a), .req_wen_i (wen_a),
        .req_lock_i (lock_a), .req_addr_i (addr_a), .req_wdata_i (wdata_a),
        .rsp_valid_o (rsp_a), .rsp_rdata_o (rdata_a),
        .sram_addr_o (sram_addr_a), .sram_ren_o (sram_ren_a), .sram_wen_o (sram_wen_a),
        .sram_wdata_o (sram_wdata_a), .sram_rdata_i (sram_rdata_a),
        .grant_id_o (gid_a), .busy_o (busy_a)
    );

    am_arbiter #(
        .NUM_PORTS (3), .HV_LENGTH (16), .ADDR_W (4),
        .RD_LATENCY (1), .RR_MODE (0), .LOCK_MAX (16)
    ) dut_b (
        .clk_i (clk), .rst_ni (rst_b_n),
        .req_valid_i (valid_b), .req_ready_o (ready_b), .req_wen_i (wen_b),
        .req_lock_i (lock_b), .req_addr_i (addr_b), .req_wdata_i (wdata_b),
        .rsp_valid_o (rsp_b), .rsp_rdata_o (rdata_b),
        .sram_addr_o (sram_addr_b), .sram_ren_o (sram_ren_b), .sram_wen_o (sram_wen_b),
        .sram_wdata_o (sram_wdata_b), .sram_rdata_i (sram_rdata_b),
        .grant_id_o (gid_b), .busy_o (busy_b)
    );

    // SRAM models: unwritten rows read as {8'h3C, 4'h0, addr}
    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    logic [15:0] wr_a, wr_b;
    logic [15:0] rd_a0, rd_a1, rd_b0;

    always @(posedge clk) begin
        if (!rst_a_n) wr_a <= '0;
        else if (sram_wen_a) begin
            mem_a[sram_addr_a] <= sram_wdata_a;
            wr_a[sram_addr_a]  <= 1'b1;
        end
        rd_a0 <= sram_ren_a ? (wr_a[sram_addr_a] ? mem_a[sram_addr_a] : {8'h3C, 4'h0, sram_addr_a}) : '0;
        rd_a1 <= rd_a0;
    end
    assign sram_rdata_a = rd_a1;

    always @(posedge clk) begin
        if (!rst_b_n) wr_b <= '0;
        else if (sram_wen_b) begin
            mem_b[sram_addr_b] <= sram_wdata_b;
            wr_b[sram_addr_b]  <= 1'b1;
        end
        rd_b0 <= sram_ren_b ? (wr_b[sram_addr_b] ? mem_b[sram_addr_b] : {8'h3C, 4'h0, sram_addr_b}) : '0;
    end
    assign sram_rdata_b = rd_b0;

    localparam logic [2:0]  RR_GNT [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    localparam logic [1:0]  RR_ID  [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    localparam logic [2:0]  RR_RSP [8] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    localparam logic [15:0] RR_DAT [8] = '{16'h0000, 16'h0000, 16'h3C01, 16'h3C02, 16'h3C03, 16'h3C01, 16'h3C02, 16'h3C03};
    localparam logic [2:0]  LK_GNT [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    localparam logic [3:0]  LK_ADR [7] = '{4'd10, 4'd10, 4'd10, 4'd10, 4'd8, 4'd9, 4'd10};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a_n = 1'b0;
        valid_a = '0;
        lock_a  = '0;
        wen_a   = '0;
        tick();
        tick();
        rst_a_n = 1'b1;
    endtask

    task automatic reset_b();
        rst_b_n = 1'b0;
        valid_b = '0;
        lock_b  = '0;
        wen_b   = '0;
        tick();
        tick();
        rst_b_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        valid_a = 3'b111;
        valid_b = 3'b111;
        wen_b   = 3'b010;
        lock_a  = 3'b111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ready_a !== 3'b000 || ready_b !== 3'b000) begin
                errors++;
                $display("FAIL reset_ready c%0d got a=%b b=%b want 000", c, ready_a, ready_b);
            end
            checks++;
            if (rsp_a !== 3'b000 || rsp_b !== 3'b000) begin
                errors++;
                $display("FAIL reset_rsp c%0d got a=%b b=%b want 000", c, rsp_a, rsp_b);
            end
            checks++;
            if ({sram_ren_a, sram_wen_a, sram_ren_b, sram_wen_b} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_sram c%0d got %b want 0000", c,
                         {sram_ren_a, sram_wen_a, sram_ren_b, sram_wen_b});
            end
            tick();
        end
        valid_a = '0;
        valid_b = '0;
        wen_b   = '0;
        lock_a  = '0;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick();
    endtask

    task automatic test_rr_reads();
        reset_a();
        addr_a[0] = 4'd1;
        addr_a[1] = 4'd2;
        addr_a[2] = 4'd3;
        valid_a   = 3'b111;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) valid_a = '0;
            @(negedge clk);
            checks++;
            if (ready_a !== RR_GNT[c] || gid_a !== RR_ID[c]) begin
                errors++;
                $display("FAIL rr_grant c%0d got ready=%b id=%0d want ready=%b id=%0d",
                         c, ready_a, gid_a, RR_GNT[c], RR_ID[c]);
            end
            checks++;
            if (rsp_a !== RR_RSP[c] || rdata_a !== RR_DAT[c]) begin
                errors++;
                $display("FAIL rr_rsp c%0d got valid=%b data=%h want valid=%b data=%h",
                         c, rsp_a, rdata_a, RR_RSP[c], RR_DAT[c]);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle_busy got %b want 0", busy_a);
        end
        tick();
    endtask

    task automatic test_fixed_priority();
        reset_b();
        addr_b[0] = 4'd4;
        addr_b[2] = 4'd6;
        valid_b   = 3'b101;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (ready_b !== 3'b001) begin
                errors++;
                $display("FAIL fp_grant c%0d got %b want 001", c, ready_b);
            end
            if (c > 0) begin
                checks++;
                if (rsp_b !== 3'b001 || rdata_b !== 16'h3C04) begin
                    errors++;
                    $display("FAIL fp_rsp c%0d got %b/%h want 001/3c04", c, rsp_b, rdata_b);
                end
            end
            tick();
        end
        valid_b = 3'b100;
        @(negedge clk);
        checks++;
        if (ready_b !== 3'b100 || gid_b !== 2'd2) begin
            errors++;
            $display("FAIL fp_starve_end got ready=%b id=%0d want 100/2", ready_b, gid_b);
        end
        tick();
        valid_b = '0;
        @(negedge clk);
        checks++;
        if (rsp_b !== 3'b100 || rdata_b !== 16'h3C06 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL fp_rsp_p2 got %b/%h busy=%b want 100/3c06 busy=1", rsp_b, rdata_b, busy_b);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_b !== 3'b000 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL fp_drain got rsp=%b busy=%b want 000/0", rsp_b, busy_b);
        end
        tick();
    endtask

    task automatic test_write_read();
        reset_b();
        valid_b    = 3'b010;
        wen_b      = 3'b010;
        addr_b[1]  = 4'd5;
        wdata_b[1] = 16'hA5A5;
        @(negedge clk);
        checks++;
        if (ready_b !== 3'b010 || sram_wen_b !== 1'b1 || sram_ren_b !== 1'b0 ||
            sram_addr_b !== 4'd5 || sram_wdata_b !== 16'hA5A5) begin
            errors++;
            $display("FAIL wr_issue got ready=%b wen=%b ren=%b addr=%0d wdata=%h want 010/1/0/5/a5a5",
                     ready_b, sram_wen_b, sram_ren_b, sram_addr_b, sram_wdata_b);
        end
        tick();
        valid_b   = 3'b001;
        wen_b     = '0;
        addr_b[0] = 4'd5;
        @(negedge clk);
        checks++;
        if (ready_b !== 3'b001 || sram_ren_b !== 1'b1 || sram_wen_b !== 1'b0 || rsp_b !== 3'b000) begin
            errors++;
            $display("FAIL rd_issue got ready=%b ren=%b wen=%b rsp=%b want 001/1/0/000",
                     ready_b, sram_ren_b, sram_wen_b, rsp_b);
        end
        tick();
        valid_b = '0;
        @(negedge clk);
        checks++;
        if (rsp_b !== 3'b001 || rdata_b !== 16'hA5A5) begin
            errors++;
            $display("FAIL rd_after_wr got %b/%h want 001/a5a5", rsp_b, rdata_b);
        end
        tick();
    endtask

    task automatic test_lock();
        reset_a();
        wen_a     = 3'b111;
        lock_a    = 3'b100;
        addr_a[0] = 4'd8;
        addr_a[1] = 4'd9;
        addr_a[2] = 4'd10;
        wdata_a   = '0;
        for (int c = 0; c < 7; c++) begin
            valid_a = (c == 0) ? 3'b100 : 3'b111;
            @(negedge clk);
            checks++;
            if (ready_a !== LK_GNT[c] || sram_wen_a !== 1'b1 || sram_addr_a !== LK_ADR[c]) begin
                errors++;
                $display("FAIL lock_grant c%0d got ready=%b wen=%b addr=%0d want %b/1/%0d",
                         c, ready_a, sram_wen_a, sram_addr_a, LK_GNT[c], LK_ADR[c]);
            end
            tick();
        end
        valid_a = '0;
        lock_a  = '0;
        wen_a   = '0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        reset_a();
        addr_a[0] = 4'd1;
        addr_a[1] = 4'd2;
        valid_a   = 3'b010;
        @(negedge clk);
        checks++;
        if (ready_a !== 3'b010) begin
            errors++;
            $display("FAIL mid_accept got %b want 010", ready_a);
        end
        tick();
        valid_a = '0;
        rst_a_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_a !== 3'b000 || ready_a !== 3'b000) begin
            errors++;
            $display("FAIL mid_in_reset got rsp=%b ready=%b want 000/000", rsp_a, ready_a);
        end
        tick();
        rst_a_n = 1'b1;
        valid_a = 3'b111;
        @(negedge clk);
        checks++;
        if (rsp_a !== 3'b000 || ready_a !== 3'b001 || gid_a !== 2'd0) begin
            errors++;
            $display("FAIL mid_after_reset got rsp=%b ready=%b id=%0d want 000/001/0", rsp_a, ready_a, gid_a);
        end
        tick();
        valid_a = '0;
        @(negedge clk);
        checks++;
        if (rsp_a !== 3'b000) begin
            errors++;
            $display("FAIL mid_dropped got %b want 000", rsp_a);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_a !== 3'b001 || rdata_a !== 16'h3C01) begin
            errors++;
            $display("FAIL mid_new_rsp got %b/%h want 001/3c01", rsp_a, rdata_a);
        end
        tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        valid_a = '0; wen_a = '0; lock_a = '0; addr_a = '0; wdata_a = '0;
        valid_b = '0; wen_b = '0; lock_b = '0; addr_b = '0; wdata_b = '0;
        #1;
        test_reset();
        test_rr_reads();
        test_fixed_priority();
        test_write_read();
        test_lock();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
